// File: rtl/udma_cfg_pkg.sv
// uDMA configuration constants shared by the TX linear channel arbiter and
// its support logic.
package udma_cfg_pkg;

    localparam int N_TX_LIN_CHANNELS = 4;
    localparam int TX_LIN_CH_ID_W    = (N_TX_LIN_CHANNELS > 1) ? $clog2(N_TX_LIN_CHANNELS) : 1;

    // Same rule as TX_LIN_CH_ID_W, for modules built with a non-default channel count.
    function automatic int ch_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udma_tx_lin_arbiter_if.sv
// Channel-side, L2-side and response signals of the TX linear arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface udma_tx_lin_arbiter_if #(
    parameter int N_CH = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [N_CH-1:0]         ch_req_i;
    logic [N_CH-1:0][AW-1:0] ch_addr_i;
    logic [N_CH-1:0]         ch_gnt_o;
    logic                    l2_req_o;
    logic [AW-1:0]           l2_addr_o;
    logic                    l2_gnt_i;
    logic                    l2_rvalid_i;
    logic [DW-1:0]           l2_rdata_i;
    logic [N_CH-1:0]         rsp_valid_o;
    logic [DW-1:0]           rsp_data_o;
    logic                    rsp_err_o;

    modport master (
        input  ch_req_i, ch_addr_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        output ch_gnt_o, l2_req_o, l2_addr_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        output ch_req_i, ch_addr_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        input  ch_gnt_o, l2_req_o, l2_addr_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/udma_arb_id_fifo.sv
// Channel-id FIFO that tracks in-flight L2 reads so responses can be routed back in order.
// The head entry is visible combinationally on data_o.
module udma_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    // The extra pointer bit tells full apart from empty.
    logic [PW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[PW-1:0]] = data_i;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o)
            rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/udma_tx_lin_arbiter.sv
// Round-robin arbiter for the uDMA TX linear channels onto a single L2 read port,
// with credit-limited outstanding reads and in-order response routing.
module udma_tx_lin_arbiter
    import udma_cfg_pkg::*;
#(
    parameter int N_CH      = N_TX_LIN_CHANNELS,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    udma_tx_lin_arbiter_if.master   bus
);
    localparam int ID_W = ch_id_width(N_CH);
    localparam int CW   = $clog2(MAX_OUTST) + 1;

    logic            slot_vld_q, slot_vld_d;
    logic [AW-1:0]   slot_addr_q, slot_addr_d;
    logic [ID_W-1:0] slot_id_q, slot_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   outst_cnt_q, outst_cnt_d;
    logic            rsp_err_q, rsp_err_d;

    logic            hs, pop, grant, win_vld;
    logic            fifo_full, fifo_empty;
    logic [ID_W-1:0] win_id, head_id, scan;
    logic [N_CH-1:0] ch_gnt;
    logic [N_CH-1:0] rsp_valid;
    logic [DW-1:0]   rsp_data;

    assign hs  = slot_vld_q && bus.l2_gnt_i;
    assign pop = bus.l2_rvalid_i && !fifo_empty;

    // First requester at or after the round-robin pointer.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        scan    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan = ID_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!win_vld && bus.ch_req_i[scan]) begin
                win_vld = 1'b1;
                win_id  = scan;
            end
        end
    end

    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        slot_id_d   = slot_id_q;
        rr_ptr_d    = rr_ptr_q;
        outst_cnt_d = outst_cnt_q + CW'(hs) - CW'(pop);
        rsp_err_d   = rsp_err_q | (bus.l2_rvalid_i && fifo_empty);
        ch_gnt      = '0;
        rsp_valid   = '0;
        rsp_data    = '0;

        // Refill only a slot that is free this cycle, and only while the
        // post-cycle in-flight count leaves a credit for it.
        grant = !rst_i && win_vld && (!slot_vld_q || hs) && (outst_cnt_d < CW'(MAX_OUTST));

        if (hs)
            slot_vld_d = 1'b0;
        if (grant) begin
            ch_gnt[win_id] = 1'b1;
            slot_vld_d     = 1'b1;
            slot_addr_d    = bus.ch_addr_i[win_id];
            slot_id_d      = win_id;
            rr_ptr_d       = (win_id == ID_W'(N_CH - 1)) ? '0 : win_id + 1'b1;
        end

        if (pop && !rst_i) begin
            rsp_valid[head_id] = 1'b1;
            rsp_data           = bus.l2_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_vld_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_id_q   <= '0;
            rr_ptr_q    <= '0;
            outst_cnt_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_id_q   <= slot_id_d;
            rr_ptr_q    <= rr_ptr_d;
            outst_cnt_q <= outst_cnt_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    udma_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs && !fifo_full),
        .data_i  (slot_id_q),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.ch_gnt_o    = ch_gnt;
    assign bus.l2_req_o    = slot_vld_q;
    assign bus.l2_addr_o   = slot_addr_q;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_data_o  = rsp_data;
    assign bus.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_udma_tx_lin_arbiter.sv
// Directed bench for udma_tx_lin_arbiter: round-robin order, credit limit,
// L2 back-pressure, response routing, orphan-response error and async reset.
module tb_udma_tx_lin_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    udma_tx_lin_arbiter_if #(.N_CH(N), .AW(AW), .DW(DW)) bus ();

    udma_tx_lin_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int ng, nh;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i           = 1'b1;
        bus.ch_req_i    = 4'hF;
        bus.l2_gnt_i    = 1'b1;
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'hDEAD;
        for (int i = 0; i < N; i++) bus.ch_addr_i[i] = 32'h1000 + i * 16;
        #2;
        chk("rst_l2_req", bus.l2_req_o, 0);
        chk("rst_gnt", bus.ch_gnt_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_err", bus.rsp_err_o, 0);
        chk("rst_addr", bus.l2_addr_o, 0);
        chk("rst_data", bus.rsp_data_o, 0);
        bus.ch_req_i    = 4'h0;
        bus.l2_rvalid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        // Round robin at full rate: responses return two cycles after grant.
        bus.l2_gnt_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.ch_req_i    = (k <= 7) ? 4'hF : 4'h0;
            bus.l2_rvalid_i = (k >= 2);
            bus.l2_rdata_i  = 32'hD000 + k;
            #2;
            chk("rr_gnt", bus.ch_gnt_o, (k <= 7) ? (64'd1 << (k % 4)) : 64'd0);
            chk("rr_l2_req", bus.l2_req_o, (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) chk("rr_addr", bus.l2_addr_o, 32'h1000 + ((k - 1) % 4) * 16);
            if (k >= 2) begin
                chk("rr_rsp", bus.rsp_valid_o, 64'd1 << ((k - 2) % 4));
                chk("rr_data", bus.rsp_data_o, 32'hD000 + k);
            end
            tick();
        end
        bus.l2_rvalid_i = 1'b0;
        #2;
        chk("rr_err", bus.rsp_err_o, 0);
        tick();

        // Credit limit: four handshakes, then stall until one response frees a credit.
        ng = 0;
        nh = 0;
        bus.ch_req_i = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #2;
            ng += (bus.ch_gnt_o != 0);
            nh += (bus.l2_req_o && bus.l2_gnt_i);
            if (k == 7) begin
                chk("cr_stall_gnt", bus.ch_gnt_o, 0);
                chk("cr_stall_req", bus.l2_req_o, 0);
            end
            tick();
        end
        chk("cr_grants", ng, 4);
        chk("cr_hs", nh, 4);
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'h55;
        #2;
        chk("cr_rsp", bus.rsp_valid_o, 4'b0001);
        chk("cr_regrant", bus.ch_gnt_o, 4'b0001);
        tick();
        bus.l2_rvalid_i = 1'b0;
        ng = 0;
        nh = 0;
        for (int k = 0; k < 5; k++) begin
            #2;
            ng += (bus.ch_gnt_o != 0);
            nh += (bus.l2_req_o && bus.l2_gnt_i);
            tick();
        end
        chk("cr_grants2", ng, 0);
        chk("cr_hs2", nh, 1);
        bus.ch_req_i    = 4'h0;
        bus.l2_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("cr_drain", bus.rsp_valid_o, 64'd1 << ((k + 1) % 4));
            tick();
        end
        bus.l2_rvalid_i = 1'b0;

        // L2 back-pressure: slot holds ch2 at 0x100, no other grant meanwhile.
        bus.ch_addr_i[2] = 32'h100;
        bus.l2_gnt_i     = 1'b0;
        bus.ch_req_i     = 4'b0100;
        #2;
        chk("bp_gnt2", bus.ch_gnt_o, 4'b0100);
        tick();
        bus.ch_req_i = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("bp_req", bus.l2_req_o, 1);
            chk("bp_addr", bus.l2_addr_o, 32'h100);
            chk("bp_nognt", bus.ch_gnt_o, 0);
            tick();
        end
        bus.l2_gnt_i = 1'b1;
        #2;
        chk("bp_next", bus.ch_gnt_o, 4'b1000);
        tick();
        bus.ch_req_i = 4'h0;
        #2;
        chk("bp_addr3", bus.l2_addr_o, 32'h1030);
        tick();
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'hD;
        #2;
        chk("bp_rsp2", bus.rsp_valid_o, 4'b0100);
        tick();
        #2;
        chk("bp_rsp3", bus.rsp_valid_o, 4'b1000);
        tick();
        bus.l2_rvalid_i = 1'b0;

        // Routing: ch1, ch3, ch0 get 0xA, 0xB, 0xC.
        bus.ch_req_i = 4'b0010;
        #2;
        chk("rt_gnt1", bus.ch_gnt_o, 4'b0010);
        tick();
        bus.ch_req_i = 4'b1000;
        #2;
        chk("rt_gnt3", bus.ch_gnt_o, 4'b1000);
        tick();
        bus.ch_req_i = 4'b0001;
        #2;
        chk("rt_gnt0", bus.ch_gnt_o, 4'b0001);
        tick();
        bus.ch_req_i = 4'h0;
        tick();
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'hA;
        #2;
        chk("rt_v1", bus.rsp_valid_o, 4'b0010);
        chk("rt_d1", bus.rsp_data_o, 32'hA);
        tick();
        bus.l2_rdata_i = 32'hB;
        #2;
        chk("rt_v3", bus.rsp_valid_o, 4'b1000);
        chk("rt_d3", bus.rsp_data_o, 32'hB);
        tick();
        bus.l2_rdata_i = 32'hC;
        #2;
        chk("rt_v0", bus.rsp_valid_o, 4'b0001);
        chk("rt_d0", bus.rsp_data_o, 32'hC);
        tick();

        // Orphan response: no valid, sticky error.
        bus.l2_rdata_i = 32'hE;
        #2;
        chk("or_valid", bus.rsp_valid_o, 0);
        chk("or_err_pre", bus.rsp_err_o, 0);
        tick();
        bus.l2_rvalid_i = 1'b0;
        #2;
        chk("or_err", bus.rsp_err_o, 1);
        tick();
        tick();
        #2;
        chk("or_err_sticky", bus.rsp_err_o, 1);
        tick();

        // Async reset with three reads outstanding and the slot loaded.
        bus.ch_req_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("ar_gnt", bus.ch_gnt_o, 64'd1 << ((k + 1) % 4));
            tick();
        end
        rst_i           = 1'b1;
        bus.l2_rvalid_i = 1'b1;
        #1;
        chk("ar_l2_req", bus.l2_req_o, 0);
        chk("ar_gnt0", bus.ch_gnt_o, 0);
        chk("ar_rsp", bus.rsp_valid_o, 0);
        chk("ar_err", bus.rsp_err_o, 0);
        chk("ar_addr", bus.l2_addr_o, 0);
        chk("ar_data", bus.rsp_data_o, 0);
        tick();
        rst_i           = 1'b0;
        bus.l2_rvalid_i = 1'b0;
        #2;
        chk("ar_first", bus.ch_gnt_o, 4'b0001);
        tick();
        bus.ch_req_i    = 4'h0;
        bus.l2_rvalid_i = 1'b1;
        #2;
        chk("ar_stale_rsp", bus.rsp_valid_o, 0);
        chk("ar_hs", bus.l2_req_o, 1);
        tick();
        bus.l2_rdata_i = 32'h77;
        #2;
        chk("ar_err_set", bus.rsp_err_o, 1);
        chk("ar_rsp0", bus.rsp_valid_o, 4'b0001);
        chk("ar_data0", bus.rsp_data_o, 32'h77);
        tick();
        bus.l2_rvalid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
